banco_registros: RTL and testbench

BANCO_REGISTROS -- requirements
Module: banco_registros

---
 rtl/banco_registros_pkg.sv | 15 +
 rtl/banco_registros_rd_port.sv | 34 +++
 rtl/banco_registros.sv | 67 ++++++
 tb/tb_banco_registros.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/banco_registros_pkg.sv
// Shared widths, types and constants for the banco_registros register file.
// Optional write-through forwarding is enabled with BANCO_REGISTROS_BYPASS_EN.
package banco_registros_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NREGS      = 2 ** DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    // Index of the hardwired-zero register (x0).
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/banco_registros_rd_port.sv
// One combinational read port: register select, x0 zeroing and, when
// BANCO_REGISTROS_BYPASS_EN is defined, forwarding of the in-flight write.
module banco_registros_rd_port
    import banco_registros_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N      = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [N],
`ifdef BANCO_REGISTROS_BYPASS_EN
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rst,
`endif
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = '0;
        if (rd_addr != ADDR_W'(ZERO_REG)) begin
            rd_data = regs[rd_addr];
`ifdef BANCO_REGISTROS_BYPASS_EN
            // A write landing on this edge is visible before it is stored.
            if (wr_en && !rst && (wr_addr == rd_addr)) begin
                rd_data = wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/banco_registros.sv
// RISC-V style integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero. Macro: BANCO_REGISTROS_BYPASS_EN.
module banco_registros
    import banco_registros_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] Add_A,
    input  logic [ADDR_W-1:0] Add_B,
    input  logic [ADDR_W-1:0] Add_Dest,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Write_En,
    output logic [DATA_W-1:0] Info_A,
    output logic [DATA_W-1:0] Info_B
);

    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [N];

    // Reset wins over a coincident write; writes to x0 are dropped so it stays zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (Write_En && (Add_Dest != ADDR_W'(ZERO_REG))) begin
            regs[Add_Dest] <= Write_Data;
        end
    end

    banco_registros_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N      (N)
    ) u_rd_a (
        .rd_addr (Add_A),
        .regs    (regs),
`ifdef BANCO_REGISTROS_BYPASS_EN
        .wr_addr (Add_Dest),
        .wr_data (Write_Data),
        .wr_en   (Write_En),
        .rst     (RST),
`endif
        .rd_data (Info_A)
    );

    banco_registros_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N      (N)
    ) u_rd_b (
        .rd_addr (Add_B),
        .regs    (regs),
`ifdef BANCO_REGISTROS_BYPASS_EN
        .wr_addr (Add_Dest),
        .wr_data (Write_Data),
        .wr_en   (Write_En),
        .rst     (RST),
`endif
        .rd_data (Info_B)
    );

endmodule

// File: tb/tb_banco_registros.sv
// Directed, scoreboard-based bench for banco_registros; a reference model of
// the register array supplies expected read values.
module tb_banco_registros;
    import banco_registros_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    reg_addr_t Add_A, Add_B, Add_Dest;
    reg_data_t Write_Data;
    logic      Write_En;
    reg_data_t Info_A, Info_B;

    reg_data_t model [NREGS];
    reg_data_t exp_q [$];
    int        checks = 0;
    int        errors = 0;

    banco_registros dut (
        .CLK        (CLK),
        .RST        (RST),
        .Add_A      (Add_A),
        .Add_B      (Add_B),
        .Add_Dest   (Add_Dest),
        .Write_Data (Write_Data),
        .Write_En   (Write_En),
        .Info_A     (Info_A),
        .Info_B     (Info_B)
    );

    always #5 CLK = ~CLK;

    // Pops one expected value from the scoreboard and compares it.
    task automatic check_one(input string tag, input reg_data_t observed);
        reg_data_t expected;
        expected = exp_q.pop_front();
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, observed, observed, expected, expected);
        end
    endtask

    // Drives both read addresses, queues expectations, samples 1 time unit later.
    task automatic read_pair(input string tag, input reg_addr_t a, input reg_addr_t b,
                             input reg_data_t exp_a, input reg_data_t exp_b);
        Add_A = a;
        Add_B = b;
        exp_q.push_back(exp_a);
        exp_q.push_back(exp_b);
        #1;
        check_one({tag, "_A"}, Info_A);
        check_one({tag, "_B"}, Info_B);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Updates the model with what one clock edge should do given current inputs.
    task automatic clock_and_model();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
        end else if (Write_En && Add_Dest != 0) begin
            model[Add_Dest] = Write_Data;
        end
        #1;
    endtask

    task automatic write_reg(input reg_addr_t dest, input reg_data_t data);
        Add_Dest   = dest;
        Write_Data = data;
        Write_En   = 1'b1;
        clock_and_model();
        Write_En   = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            read_pair(tag, reg_addr_t'(i), reg_addr_t'(NREGS - 1 - i),
                      model[i], model[NREGS - 1 - i]);
        end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        RST = 1'b1; Write_En = 1'b0; Add_A = '0; Add_B = '0;
        Add_Dest = '0; Write_Data = '0;
        clock_and_model();
        clock_and_model();
        RST = 1'b0;

        read_pair("reset_3_31", 5'd3, 5'd31, 32'd0, 32'd0);
        sweep("reset_sweep");

        write_reg(5'd1, 32'd20);
        write_reg(5'd2, 32'd25);
        write_reg(5'd3, 32'd5);
        write_reg(5'd4, 32'd8);
        read_pair("rd_3_1", 5'd3, 5'd1, 32'd5, 32'd20);
        read_pair("rd_2_1", 5'd2, 5'd1, 32'd25, 32'd20);

        write_reg(5'd0, 32'd30);
        read_pair("x0_write", 5'd3, 5'd0, 32'd5, 32'd0);

        Add_Dest = 5'd4; Write_Data = 32'd99; Write_En = 1'b0;
        clock_and_model();
        read_pair("we_low", 5'd4, 5'd4, 32'd8, 32'd8);

        // Held write over several edges rewrites the same value only.
        Add_Dest = 5'd9; Write_Data = 32'hCAFE_F00D; Write_En = 1'b1;
        for (int k = 0; k < 3; k++) clock_and_model();
        Write_En = 1'b0;
        read_pair("held_write", 5'd9, 5'd4, 32'hCAFE_F00D, 32'd8);

        for (int k = 0; k < 20; k++) begin
            write_reg(reg_addr_t'($urandom_range(8, 31)), reg_data_t'($urandom));
        end
        write_reg(5'd31, 32'hFFFF_FFFF);
        sweep("rand_sweep");

        // Read-during-write on x7 (never written before this point).
        Add_Dest = 5'd7; Write_Data = 32'd4; Write_En = 1'b1;
`ifdef BANCO_REGISTROS_BYPASS_EN
        read_pair("rdw_pre", 5'd7, 5'd7, 32'd4, 32'd4);
`else
        read_pair("rdw_pre", 5'd7, 5'd7, 32'd0, 32'd0);
`endif
        clock_and_model();
        Write_En = 1'b0;
        read_pair("rdw_post", 5'd7, 5'd7, 32'd4, 32'd4);

        write_reg(5'd5, 32'd55);
        read_pair("pre_rst5", 5'd5, 5'd1, 32'd55, 32'd20);
        RST = 1'b1; Write_En = 1'b1; Add_Dest = 5'd5; Write_Data = 32'd77;
        clock_and_model();
        RST = 1'b0; Write_En = 1'b0;
        read_pair("rst_vs_we", 5'd5, 5'd3, 32'd0, 32'd0);
        sweep("post_rst_sweep");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
